// File: rtl/f1_pkg.sv
// f1_pkg: shared state type, LFSR seed and LFSR tap masks for the start-light sequencer
package f1_pkg;
  typedef enum logic [2:0] {IDLE, SEQ, DELAY, WAIT_REACT, DONE} f1_state_t;
  localparam int LFSR_SEED = 1;
  // Maximal-length tap masks for a shift-left Fibonacci LFSR; bit k set means register bit k feeds the xor
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h0000_0060;
    endcase
  endfunction
endpackage

// File: rtl/f1_light_sequencer_lfsr.sv
// lfsr_gen: free-running Fibonacci LFSR, shift left, seeded to LFSR_SEED on reset
//   clk : system clock
//   rst : asynchronous active-low reset
//   en  : advance enable
//   out : current LFSR value (never zero)
module lfsr_gen
  import f1_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = en ? {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)} : lfsr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= WIDTH'(LFSR_SEED);
    else lfsr_q <= lfsr_d;
  assign out = lfsr_q;
endmodule

// File: rtl/f1_light_sequencer.sv
// f1_light_sequencer: F1 start-light sequence with random hold delay and reaction timer
//   clk, rst      : system clock, asynchronous active-low reset
//   tick          : divider pulse, used only while filling lights or counting the delay
//   trigger       : start request (honoured in IDLE and DONE)
//   react         : driver button
//   div_en        : divider enable, high while a tick-paced phase runs
//   lights        : light pattern, bit 0 first
//   reaction_time : captured reaction time in clk cycles (saturating)
//   time_valid    : one-cycle strobe when reaction_time updates
//   jump_start    : sticky flag, react seen before lights-out
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = 8,
  parameter int LFSR_WIDTH = 7,
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  trigger,
  input  logic                  react,
  output logic                  div_en,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [TIME_WIDTH-1:0] reaction_time,
  output logic                  time_valid,
  output logic                  jump_start
);
  f1_state_t             state_q;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [LFSR_WIDTH-1:0] lfsr, delay_cnt_q, delay_cnt_d;
  logic [TIME_WIDTH-1:0] timer_q, timer_d, reaction_time_q;
  logic                  div_en_q, time_valid_q, jump_start_q;
  lfsr_gen #(.WIDTH(LFSR_WIDTH)) u_lfsr (.clk(clk), .rst(rst), .en(1'b1), .out(lfsr));
  always_comb timer_d = &timer_q ? timer_q : timer_q + 1'b1;
  always_comb delay_cnt_d = delay_cnt_q - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q         <= IDLE;
      lights_q        <= '0;
      div_en_q        <= 1'b0;
      reaction_time_q <= '0;
      time_valid_q    <= 1'b0;
      jump_start_q    <= 1'b0;
      delay_cnt_q     <= '0;
      timer_q         <= '0;
    end else begin
      time_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE:
          if (trigger) begin
            state_q      <= SEQ;
            lights_q     <= '0;
            jump_start_q <= 1'b0;
            div_en_q     <= 1'b1;
          end
        SEQ, DELAY:
          // react outranks tick: a press before lights-out is a jump start
          if (react) begin
            state_q      <= DONE;
            lights_q     <= '0;
            jump_start_q <= 1'b1;
            div_en_q     <= 1'b0;
          end else if (tick) begin
            if (state_q == SEQ) begin
              if (&lights_q) begin
                delay_cnt_q <= lfsr;
                state_q     <= DELAY;
              end else lights_q <= {lights_q[NUM_LIGHTS-2:0], 1'b1};
            end else if (delay_cnt_q == LFSR_WIDTH'(1)) begin
              state_q  <= WAIT_REACT;
              lights_q <= '0;
              timer_q  <= '0;
              div_en_q <= 1'b0;
            end else delay_cnt_q <= delay_cnt_d;
          end
        WAIT_REACT: begin
          timer_q <= timer_d;
          if (react) begin
            reaction_time_q <= timer_q;
            time_valid_q    <= 1'b1;
            state_q         <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign div_en        = div_en_q;
  assign lights        = lights_q;
  assign reaction_time = reaction_time_q;
  assign time_valid    = time_valid_q;
  assign jump_start    = jump_start_q;
endmodule

// File: tb/tb_f1_light_sequencer.sv
// tb_f1_light_sequencer: table, directed and random checks against a light-count/phase reference model
module tb_f1_light_sequencer;
  logic        clk = 1'b0;
  logic        rst, tick, trigger, react;
  logic        div_en, time_valid, jump_start;
  logic [7:0]  lights;
  logic [15:0] reaction_time;
  int vectors = 0;
  int miscompares = 0;
  // model: m_mode 0 idle, 1 filling, 2 delay, 3 waiting for react, 4 done
  int m_mode, m_n, m_left, m_timer, m_lfsr, m_rt;
  bit m_js, m_tv;
  typedef struct {
    logic trg, tk, rc;
    logic [7:0] l;
    logic de, js, tv;
  } vec_t;
  vec_t tbl[12];
  f1_light_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
    .div_en(div_en), .lights(lights), .reaction_time(reaction_time),
    .time_valid(time_valid), .jump_start(jump_start)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_mode = 0; m_n = 0; m_left = 0; m_timer = 0; m_lfsr = 1; m_rt = 0; m_js = 0; m_tv = 0;
  endtask
  task automatic model_step();
    int nl;
    nl = ((m_lfsr << 1) & 127) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
    m_tv = 0;
    case (m_mode)
      0, 4: if (trigger) begin m_mode = 1; m_n = 0; m_js = 0; end
      1, 2:
        if (react) begin m_mode = 4; m_n = 0; m_js = 1; end
        else if (tick && m_mode == 1) begin
          if (m_n == 8) begin m_left = m_lfsr; m_mode = 2; end
          else m_n++;
        end else if (tick) begin
          if (m_left == 1) begin m_n = 0; m_timer = 0; m_mode = 3; end
          else m_left--;
        end
      3: begin
        if (react) begin m_rt = m_timer; m_tv = 1; m_mode = 4; end
        m_timer = (m_timer >= 65535) ? 65535 : m_timer + 1;
      end
      default: m_mode = 0;
    endcase
    m_lfsr = nl;
  endtask
  task automatic cmp(input string nm, input logic [7:0] el, input logic ede, input logic [15:0] ert,
                     input logic etv, input logic ejs);
    vectors++;
    if ({lights, div_en, reaction_time, time_valid, jump_start} !== {el, ede, ert, etv, ejs}) begin
      miscompares++;
      $display("FAIL %s @%0t: lights=%h div_en=%b rt=%h tv=%b js=%b, required lights=%h div_en=%b rt=%h tv=%b js=%b",
               nm, $time, lights, div_en, reaction_time, time_valid, jump_start, el, ede, ert, etv, ejs);
    end
  endtask
  task automatic cnt(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, got, exp);
    end
  endtask
  task automatic mcheck(input string nm);
    cmp(nm, 8'((1 << m_n) - 1), m_mode == 1 || m_mode == 2, 16'(m_rt), m_tv, m_js);
  endtask
  task automatic step(input logic trg, input logic tk, input logic rc, input string nm);
    trigger = trg; tick = tk; react = rc;
    @(posedge clk);
    model_step();
    #1;
    if (nm != "") mcheck(nm);
  endtask
  initial begin
    logic trg, tk, rc;
    int ticks;
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}
    };
    rst = 1'b0; tick = 1'b0; trigger = 1'b0; react = 1'b0;
    model_reset();
    #2 cmp("in_reset", 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);
    #10 rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, "idle_after_reset");
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].trg, tbl[i].tk, tbl[i].rc, "");
      cmp($sformatf("table[%0d]", i), tbl[i].l, tbl[i].de, 16'h0, tbl[i].tv, tbl[i].js);
    end
    step(1'b1, 1'b0, 1'b0, "restart");
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, "fill_tick");
      repeat (3) step(1'b0, 1'b0, 1'b0, "fill_gap");
    end
    for (int i = 0; i < 200 && m_lfsr != 5; i++) step(1'b0, 1'b0, 1'b0, "hold_full");
    cnt("lfsr_reaches_5", m_lfsr, 5);
    step(1'b0, 1'b1, 1'b0, "seq_exit");
    ticks = 0;
    for (int t = 1; t <= 10; t++) begin
      step(1'b0, 1'b1, 1'b0, "delay_tick");
      if (lights == 8'h00) begin ticks = t; break; end
      repeat (3) step(1'b0, 1'b0, 1'b0, "delay_gap");
    end
    cnt("delay_ticks", ticks, 5);
    cnt("div_en_drop", int'(div_en), 0);
    repeat (37) step(1'b0, 1'b0, 1'b0, "wait_react");
    step(1'b0, 1'b0, 1'b1, "react");
    cnt("rt37", int'(reaction_time), 37);
    cnt("tv_pulse", int'(time_valid), 1);
    step(1'b0, 1'b0, 1'b0, "done");
    cnt("tv_once", int'(time_valid), 0);
    step(1'b1, 1'b0, 1'b0, "sat_trig");
    repeat (9) step(1'b0, 1'b1, 1'b0, "sat_fill");
    for (int i = 0; i < 200 && m_mode == 2; i++) step(1'b0, 1'b1, 1'b0, "sat_delay");
    repeat (70000) step(1'b0, 1'b0, 1'b0, "sat_wait");
    step(1'b0, 1'b0, 1'b1, "sat_react");
    cnt("rt_saturated", int'(reaction_time), 65535);
    step(1'b1, 1'b0, 1'b0, "ar_trig");
    repeat (9) step(1'b0, 1'b1, 1'b0, "ar_fill");
    #2 rst = 1'b0;
    #1 cmp("async_reset", 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);
    model_reset();
    #3 rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      trg = ($urandom_range(9) == 0);
      tk = ($urandom_range(2) == 0);
      rc = (m_mode == 1 || m_mode == 2) ? ($urandom_range(399) == 0) : ($urandom_range(14) == 0);
      step(trg, tk, rc, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
